stage3_execute: RTL and testbench

//  RV32IM execute stage. Sits between the ID/EX register and the memory stage.

---
 rtl/stage3_execute.sv | 227 ++++++++++++++++++++++
 tb/tb_stage3_execute.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stage3_execute.sv
// RV32IM execute stage: single-cycle ALU/branch/address paths plus a 32-step
// restoring divider that stalls upstream via ex_busy, registered into EX/MEM.
module stage3_execute #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter int unsigned DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        id_ex_valid,
    input  logic [31:0] id_ex_ir,
    input  logic [31:0] id_ex_pc,
    input  logic [31:0] id_ex_a,
    input  logic [31:0] id_ex_b,
    input  logic [31:0] id_ex_imm,
    output logic        ex_busy,
    output logic        ex_mem_valid,
    output logic [31:0] ex_mem_ir,
    output logic [31:0] ex_mem_alu_output,
    output logic [31:0] ex_mem_b,
    output logic        ex_mem_load_inst,
    output logic        ex_mem_store_inst,
    output logic        branch_taken,
    output logic [31:0] branch_target
);
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] quo_q, rem_q, dvs_q, div_ir_q;
    logic        neg_q_q, neg_r_q, want_rem_q;

    logic        valid_q, load_q, store_q, taken_q;
    logic [31:0] ir_q, alu_q, b_q, target_q;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        is_m, is_div, div_signed, div_want_rem, div_by_zero, div_ovf, div_start;
    logic [31:0] op_b, alu_d, target_d, a_mag, b_mag;
    logic        taken_d;
    logic [4:0]  shamt;
    logic signed [31:0] sra_res;
    logic [63:0] mul_a, mul_b, mul_p;
    logic [32:0] rem_sh, rem_diff;
    logic [31:0] rem_d, quo_d, quo_fix, rem_fix;

    assign opcode       = id_ex_ir[6:0];
    assign funct3       = id_ex_ir[14:12];
    assign funct7       = id_ex_ir[31:25];
    assign is_m         = (opcode == OPC_OP) && (funct7 == 7'b0000001);
    assign is_div       = is_m && funct3[2];
    assign div_signed   = !funct3[0];
    assign div_want_rem = funct3[1];
    assign div_by_zero  = (id_ex_b == '0);
    assign div_ovf      = div_signed && (id_ex_a == 32'h80000000) && (id_ex_b == '1);
    assign div_start    = (state_q == S_IDLE) && id_ex_valid && !flush && is_div
                          && !div_by_zero && !div_ovf;
    assign ex_busy      = reset && ((state_q == S_DIV) || div_start);

    assign op_b    = (opcode == OPC_OP) ? id_ex_b : id_ex_imm;
    assign shamt   = op_b[4:0];
    assign sra_res = $signed(id_ex_a) >>> shamt;

    // One 64-bit multiplier; operand extension selects MULH/MULHSU/MULHU, low half is MUL.
    assign mul_a = {{32{id_ex_a[31] & (funct3 == 3'b001 || funct3 == 3'b010)}}, id_ex_a};
    assign mul_b = {{32{id_ex_b[31] & (funct3 == 3'b001)}}, id_ex_b};
    assign mul_p = mul_a * mul_b;

    assign a_mag = (div_signed && id_ex_a[31]) ? (~id_ex_a + 32'd1) : id_ex_a;
    assign b_mag = (div_signed && id_ex_b[31]) ? (~id_ex_b + 32'd1) : id_ex_b;

    assign rem_sh   = {rem_q, quo_q[31]};
    assign rem_diff = rem_sh - {1'b0, dvs_q};
    assign rem_d    = rem_diff[32] ? rem_sh[31:0] : rem_diff[31:0];
    assign quo_d    = {quo_q[30:0], !rem_diff[32]};
    assign quo_fix  = neg_q_q ? (~quo_q + 32'd1) : quo_q;
    assign rem_fix  = neg_r_q ? (~rem_q + 32'd1) : rem_q;

    always_comb begin
        alu_d    = '0;
        taken_d  = 1'b0;
        target_d = '0;
        case (opcode)
            OPC_OP, OPC_OPIMM: begin
                if (is_m) begin
                    case (funct3)
                        3'b000:                   alu_d = mul_p[31:0];
                        3'b001, 3'b010, 3'b011:   alu_d = mul_p[63:32];
                        // Only the divide corner cases reach here as single-cycle ops.
                        default: alu_d = div_by_zero ? (div_want_rem ? id_ex_a : '1)
                                                     : (div_want_rem ? '0 : 32'h80000000);
                    endcase
                end else begin
                    case (funct3)
                        3'b000: alu_d = (opcode == OPC_OP && funct7[5]) ? id_ex_a - op_b
                                                                          : id_ex_a + op_b;
                        3'b001: alu_d = id_ex_a << shamt;
                        3'b010: alu_d = {31'd0, $signed(id_ex_a) < $signed(op_b)};
                        3'b011: alu_d = {31'd0, id_ex_a < op_b};
                        3'b100: alu_d = id_ex_a ^ op_b;
                        3'b101: alu_d = funct7[5] ? sra_res : (id_ex_a >> shamt);
                        3'b110: alu_d = id_ex_a | op_b;
                        default: alu_d = id_ex_a & op_b;
                    endcase
                end
            end
            OPC_LOAD, OPC_STORE: alu_d = id_ex_a + id_ex_imm;
            OPC_LUI:             alu_d = id_ex_imm;
            OPC_AUIPC:           alu_d = id_ex_pc + id_ex_imm;
            OPC_JAL: begin
                alu_d    = id_ex_pc + 32'd4;
                taken_d  = 1'b1;
                target_d = id_ex_pc + id_ex_imm;
            end
            OPC_JALR: begin
                alu_d    = id_ex_pc + 32'd4;
                taken_d  = 1'b1;
                target_d = (id_ex_a + id_ex_imm) & ~32'd1;
            end
            OPC_BRANCH: begin
                target_d = id_ex_pc + id_ex_imm;
                case (funct3)
                    3'b000:  taken_d = (id_ex_a == id_ex_b);
                    3'b001:  taken_d = (id_ex_a != id_ex_b);
                    3'b100:  taken_d = ($signed(id_ex_a) < $signed(id_ex_b));
                    3'b101:  taken_d = ($signed(id_ex_a) >= $signed(id_ex_b));
                    3'b110:  taken_d = (id_ex_a < id_ex_b);
                    3'b111:  taken_d = (id_ex_a >= id_ex_b);
                    default: taken_d = 1'b0;
                endcase
            end
            default: alu_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            div_ir_q   <= '0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            want_rem_q <= 1'b0;
            valid_q    <= 1'b0;
            ir_q       <= NOP_INSTR;
            alu_q      <= '0;
            b_q        <= '0;
            load_q     <= 1'b0;
            store_q    <= 1'b0;
            taken_q    <= 1'b0;
            target_q   <= '0;
        end else begin
            valid_q  <= 1'b0;
            ir_q     <= NOP_INSTR;
            alu_q    <= '0;
            b_q      <= '0;
            load_q   <= 1'b0;
            store_q  <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (div_start) begin
                        state_q    <= S_DIV;
                        cnt_q      <= '0;
                        quo_q      <= a_mag;
                        rem_q      <= '0;
                        dvs_q      <= b_mag;
                        div_ir_q   <= id_ex_ir;
                        neg_q_q    <= div_signed && (id_ex_a[31] ^ id_ex_b[31]);
                        neg_r_q    <= div_signed && id_ex_a[31];
                        want_rem_q <= div_want_rem;
                    end else if (id_ex_valid && !flush) begin
                        valid_q  <= 1'b1;
                        ir_q     <= id_ex_ir;
                        alu_q    <= alu_d;
                        b_q      <= id_ex_b;
                        load_q   <= (opcode == OPC_LOAD);
                        store_q  <= (opcode == OPC_STORE);
                        taken_q  <= taken_d;
                        target_q <= target_d;
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        quo_q <= quo_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'(DIV_STEPS - 1)) state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    if (!flush) begin
                        valid_q <= 1'b1;
                        ir_q    <= div_ir_q;
                        alu_q   <= want_rem_q ? rem_fix : quo_fix;
                    end
                end
            endcase
        end
    end

    assign ex_mem_valid      = valid_q;
    assign ex_mem_ir         = ir_q;
    assign ex_mem_alu_output = alu_q;
    assign ex_mem_b          = b_q;
    assign ex_mem_load_inst  = load_q;
    assign ex_mem_store_inst = store_q;
    assign branch_taken      = taken_q;
    assign branch_target     = target_q;
endmodule

// File: tb/tb_stage3_execute.sv
// Directed-vector bench for stage3_execute: single-cycle ops, divider timing,
// divide corner cases, flush and asynchronous reset during a divide.
module tb_stage3_execute;
    logic        clk = 1'b0;
    logic        reset, flush, id_ex_valid;
    logic [31:0] id_ex_ir, id_ex_pc, id_ex_a, id_ex_b, id_ex_imm;
    logic        ex_busy, ex_mem_valid, ex_mem_load_inst, ex_mem_store_inst, branch_taken;
    logic [31:0] ex_mem_ir, ex_mem_alu_output, ex_mem_b, branch_target;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    stage3_execute #(.NOP_INSTR(32'h00000013), .DIV_STEPS(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .id_ex_valid(id_ex_valid),
        .id_ex_ir(id_ex_ir), .id_ex_pc(id_ex_pc), .id_ex_a(id_ex_a),
        .id_ex_b(id_ex_b), .id_ex_imm(id_ex_imm), .ex_busy(ex_busy),
        .ex_mem_valid(ex_mem_valid), .ex_mem_ir(ex_mem_ir),
        .ex_mem_alu_output(ex_mem_alu_output), .ex_mem_b(ex_mem_b),
        .ex_mem_load_inst(ex_mem_load_inst), .ex_mem_store_inst(ex_mem_store_inst),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [6:0] opc);
        return {f7, 10'd0, f3, 5'd0, opc};
    endfunction

    task automatic drive(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm);
        id_ex_valid = 1'b1;
        flush       = 1'b0;
        id_ex_ir    = ir;
        id_ex_pc    = pc;
        id_ex_a     = a;
        id_ex_b     = b;
        id_ex_imm   = imm;
    endtask

    task automatic issue(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm);
        drive(ir, pc, a, b, imm);
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int unsigned cyc,
                           output logic bubble_ok);
        drive(ir, 32'h0, a, b, 32'h0);
        #1;
        cyc       = ex_busy ? 1 : 0;
        bubble_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (!ex_busy) break;
            cyc++;
            if (ex_mem_valid !== 1'b0) bubble_ok = 1'b0;
        end
        @(posedge clk);
        #1;
        res         = ex_mem_alu_output;
        id_ex_valid = 1'b0;
    endtask

    localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, M = 7'b0000001;

    initial begin
        logic [31:0] res;
        int unsigned cyc;
        logic        ok, stale;

        reset = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        id_ex_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", {31'd0, ex_mem_valid}, 32'd0);
        check_eq("rst_ir", ex_mem_ir, 32'h00000013);
        check_eq("rst_alu", ex_mem_alu_output, 32'd0);
        check_eq("rst_flags", {28'd0, ex_mem_load_inst, ex_mem_store_inst, branch_taken, ex_busy}, 32'd0);
        check_eq("rst_target", branch_target, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        issue(mk(7'h7f, 3'b000, OPI), 32'h0, 32'd5, 32'h0, 32'hFFFFFFF9);
        check_eq("addi_alu", ex_mem_alu_output, 32'hFFFFFFFE);
        check_eq("addi_flags", {29'd0, ex_mem_valid, ex_mem_load_inst, ex_mem_store_inst}, 32'b100);

        issue(mk(7'h00, 3'b010, 7'b0000011), 32'h0, 32'h1000, 32'h0, 32'd8);
        check_eq("lw_alu", ex_mem_alu_output, 32'h1008);
        check_eq("lw_load", {31'd0, ex_mem_load_inst}, 32'd1);

        issue(mk(7'h00, 3'b010, 7'b0100011), 32'h0, 32'h2000, 32'hDEADBEEF, 32'd4);
        check_eq("sw_alu", ex_mem_alu_output, 32'h2004);
        check_eq("sw_b", ex_mem_b, 32'hDEADBEEF);
        check_eq("sw_store", {30'd0, ex_mem_load_inst, ex_mem_store_inst}, 32'b01);

        issue(mk(7'h00, 3'b100, 7'b1100011), 32'h40, 32'hFFFFFFFF, 32'd1, 32'd16);
        check_eq("blt_taken", {31'd0, branch_taken}, 32'd1);
        check_eq("blt_target", branch_target, 32'h50);
        check_eq("blt_alu_valid", {ex_mem_alu_output[30:0], ex_mem_valid}, 32'd1);

        issue(mk(7'h00, 3'b000, 7'b1100011), 32'h40, 32'd1, 32'd2, 32'd16);
        check_eq("beq_not_taken", {31'd0, branch_taken}, 32'd0);

        issue(mk(7'h00, 3'b000, 7'b1100111), 32'h20, 32'h103, 32'h0, 32'h0);
        check_eq("jalr_target", branch_target, 32'h102);
        check_eq("jalr_alu", ex_mem_alu_output, 32'h24);

        issue(mk(7'h00, 3'b000, 7'b1101111), 32'h200, 32'h0, 32'h0, 32'h10);
        check_eq("jal_alu", ex_mem_alu_output, 32'h204);
        check_eq("jal_target", branch_target, 32'h210);

        issue(mk(7'h00, 3'b000, 7'b0010111), 32'h100, 32'h0, 32'h0, 32'h1000);
        check_eq("auipc", ex_mem_alu_output, 32'h1100);
        issue(mk(7'h00, 3'b000, 7'b0110111), 32'h100, 32'h0, 32'h0, 32'h12345000);
        check_eq("lui", ex_mem_alu_output, 32'h12345000);

        issue(mk(7'h20, 3'b000, OP), 32'h0, 32'd3, 32'd5, 32'h0);
        check_eq("sub", ex_mem_alu_output, 32'hFFFFFFFE);
        issue(mk(7'h20, 3'b101, OP), 32'h0, 32'h80000000, 32'd4, 32'h0);
        check_eq("sra", ex_mem_alu_output, 32'hF8000000);
        issue(mk(7'h00, 3'b101, OP), 32'h0, 32'h80000000, 32'd36, 32'h0);
        check_eq("srl_shamt5", ex_mem_alu_output, 32'h08000000);
        issue(mk(7'h00, 3'b010, OP), 32'h0, 32'd1, 32'hFFFFFFFF, 32'h0);
        check_eq("slt", ex_mem_alu_output, 32'd0);
        issue(mk(7'h00, 3'b011, OP), 32'h0, 32'd1, 32'hFFFFFFFF, 32'h0);
        check_eq("sltu", ex_mem_alu_output, 32'd1);

        issue(mk(M, 3'b000, OP), 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
        check_eq("mul", ex_mem_alu_output, 32'd1);
        issue(mk(M, 3'b001, OP), 32'h0, 32'hFFFFFFFF, 32'd2, 32'h0);
        check_eq("mulh", ex_mem_alu_output, 32'hFFFFFFFF);
        issue(mk(M, 3'b010, OP), 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
        check_eq("mulhsu", ex_mem_alu_output, 32'hFFFFFFFF);
        issue(mk(M, 3'b011, OP), 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
        check_eq("mulhu", ex_mem_alu_output, 32'hFFFFFFFE);

        id_ex_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("bubble_valid", {31'd0, ex_mem_valid}, 32'd0);
        check_eq("bubble_ir", ex_mem_ir, 32'h00000013);

        run_div(mk(M, 3'b100, OP), 32'hFFFFFFF9, 32'd2, res, cyc, ok);
        check_eq("div_busy_cycles", cyc, 32'd33);
        check_eq("div_bubble_while_busy", {31'd0, ok}, 32'd1);
        check_eq("div_result", res, 32'hFFFFFFFD);
        check_eq("div_valid", {31'd0, ex_mem_valid}, 32'd1);
        check_eq("div_ir", ex_mem_ir, mk(M, 3'b100, OP));

        run_div(mk(M, 3'b110, OP), 32'hFFFFFFF9, 32'd2, res, cyc, ok);
        check_eq("rem_result", res, 32'hFFFFFFFF);
        run_div(mk(M, 3'b101, OP), 32'hFFFFFFFF, 32'd16, res, cyc, ok);
        check_eq("divu_result", res, 32'h0FFFFFFF);
        run_div(mk(M, 3'b111, OP), 32'd100, 32'd7, res, cyc, ok);
        check_eq("remu_result", res, 32'd2);

        drive(mk(M, 3'b101, OP), 32'h0, 32'd1234, 32'd0, 32'h0);
        #1;
        check_eq("divu0_busy", {31'd0, ex_busy}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("divu0_result", ex_mem_alu_output, 32'hFFFFFFFF);
        issue(mk(M, 3'b110, OP), 32'h0, 32'd1234, 32'd0, 32'h0);
        check_eq("rem0_result", ex_mem_alu_output, 32'd1234);

        drive(mk(M, 3'b100, OP), 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h0);
        #1;
        check_eq("ovf_busy", {31'd0, ex_busy}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("ovf_div", ex_mem_alu_output, 32'h80000000);
        issue(mk(M, 3'b110, OP), 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h0);
        check_eq("ovf_rem", ex_mem_alu_output, 32'd0);

        drive(mk(M, 3'b100, OP), 32'h0, 32'd100, 32'd7, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        flush       = 1'b1;
        id_ex_valid = 1'b0;
        #1;
        check_eq("flush_busy_same_cycle", {31'd0, ex_busy}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush_busy_drop", {31'd0, ex_busy}, 32'd0);
        check_eq("flush_bubble", {31'd0, ex_mem_valid}, 32'd0);
        issue(mk(7'h00, 3'b000, OPI), 32'h0, 32'd1, 32'h0, 32'd2);
        check_eq("after_flush_addi", ex_mem_alu_output, 32'd3);
        id_ex_valid = 1'b0;
        stale = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ex_mem_valid !== 1'b0) stale = 1'b1;
        end
        check_eq("flush_no_stale", {31'd0, stale}, 32'd0);

        drive(mk(M, 3'b100, OP), 32'h0, 32'd100, 32'd7, 32'h0);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_eq("arst_busy", {31'd0, ex_busy}, 32'd0);
        check_eq("arst_ir", ex_mem_ir, 32'h00000013);
        check_eq("arst_outs", {28'd0, ex_mem_valid, ex_mem_load_inst, ex_mem_store_inst, branch_taken}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        issue(mk(7'h00, 3'b000, OPI), 32'h0, 32'd1, 32'h0, 32'd2);
        check_eq("after_rst_addi", ex_mem_alu_output, 32'd3);
        check_eq("after_rst_valid", {31'd0, ex_mem_valid}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
